// File: rtl/tap_controller.sv
// ---------------------------------------------------------------------------
// tap_controller
//
// IEEE 1149.1 TAP state machine plus instruction register. It sits directly
// upstream of the BIST boundary register chain. It decodes TMS into the
// sixteen TAP states and holds the current instruction. It also generates the
// chain controls and selects the serial source that is presented on TDO.
//
// Ports
//   TCK            in   test clock, all state updates on the rising edge
//   TRST_n         in   asynchronous active-low reset
//   TMS            in   mode select, sampled on TCK rising edge
//   TDI            in   serial data in, sampled on TCK rising edge
//   BIST_Shift_out in   serial output of the BIST register chain
//   TDO            out  serial data out (Shift-IR / Shift-DR source, else 0)
//   TDO_en         out  high in Shift-IR / Shift-DR
//   Shift_DR       out  high in Shift-DR while BIST is the selected DR
//   Test_Log_Res   out  high while the FSM is in Test-Logic-Reset
//   BIST_Sh_en     out  BIST shift-clock enable (Capture-DR / Shift-DR)
//   BIST_Com_en    out  BIST commit-clock enable (Update-DR)
//   IR_out         out  current (updated) instruction
// ---------------------------------------------------------------------------
module tap_controller #(
  parameter int              IR_W        = 4,
  parameter logic [IR_W-1:0] BIST_OPCODE = IR_W'(4'b0010)
) (
  input  logic            TCK,
  input  logic            TRST_n,
  input  logic            TMS,
  input  logic            TDI,
  input  logic            BIST_Shift_out,
  output logic            TDO,
  output logic            TDO_en,
  output logic            Shift_DR,
  output logic            Test_Log_Res,
  output logic            BIST_Sh_en,
  output logic            BIST_Com_en,
  output logic [IR_W-1:0] IR_out
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  localparam logic [IR_W-1:0] IR_ONES    = {IR_W{1'b1}};
  // Capture pattern: LSBs fixed to 01 as the IR integrity check.
  localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b1}}, 2'b01};

  tap_state_t      state_r, state_next_s;
  logic [IR_W-1:0] ir_r, ir_next_s;
  logic [IR_W-1:0] ir_sh_r, ir_sh_next_s;
  logic            bypass_r, bypass_next_s;
  logic            bist_sel_r, bist_sel_next_s;
  logic            tdo_en_r, shift_dr_r, tlr_r, sh_en_r, com_en_r;
  logic            tdo_s;

  // TAP state register
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      state_r <= TLR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // TAP next-state decode from TMS
  always_comb begin
    state_next_s = TLR;
    case (state_r)
      TLR:    state_next_s = TMS ? TLR    : RTI;
      RTI:    state_next_s = TMS ? SEL_DR : RTI;
      SEL_DR: state_next_s = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_next_s = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_next_s = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_next_s = TMS ? UPD_DR : PA_DR;
      PA_DR:  state_next_s = TMS ? EX2_DR : PA_DR;
      EX2_DR: state_next_s = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_next_s = TMS ? SEL_DR : RTI;
      SEL_IR: state_next_s = TMS ? TLR    : CAP_IR;
      CAP_IR: state_next_s = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_next_s = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_next_s = TMS ? UPD_IR : PA_IR;
      PA_IR:  state_next_s = TMS ? EX2_IR : PA_IR;
      EX2_IR: state_next_s = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_next_s = TMS ? SEL_DR : RTI;
      default: state_next_s = TLR;
    endcase
  end

  // Instruction shift register and bypass bit next values
  always_comb begin
    ir_sh_next_s  = ir_sh_r;
    bypass_next_s = bypass_r;
    case (state_r)
      CAP_IR:  ir_sh_next_s  = IR_CAPTURE;
      SH_IR:   ir_sh_next_s  = {TDI, ir_sh_r[IR_W-1:1]};
      CAP_DR:  bypass_next_s = 1'b0;
      SH_DR:   bypass_next_s = TDI;
      default: begin
        ir_sh_next_s  = ir_sh_r;
        bypass_next_s = bypass_r;
      end
    endcase
  end

  // Instruction next value: forced to BYPASS on entering TLR, loaded on
  // entering Update-IR (ir_sh is stable in Exit1/Exit2, so nothing is lost),
  // otherwise held so a DR scan never sees the instruction change.
  always_comb begin
    ir_next_s = ir_r;
    if (state_next_s == TLR) begin
      ir_next_s = IR_ONES;
    end else if (state_next_s == UPD_IR) begin
      ir_next_s = ir_sh_r;
    end else begin
      ir_next_s = ir_r;
    end
    bist_sel_next_s = (ir_next_s == BIST_OPCODE);
  end

  // Shift registers, instruction and decoded outputs, all from next values
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      ir_sh_r    <= IR_ONES;
      bypass_r   <= 1'b0;
      ir_r       <= IR_ONES;
      bist_sel_r <= 1'b0;
      tdo_en_r   <= 1'b0;
      shift_dr_r <= 1'b0;
      tlr_r      <= 1'b1;
      sh_en_r    <= 1'b0;
      com_en_r   <= 1'b0;
    end else begin
      ir_sh_r    <= ir_sh_next_s;
      bypass_r   <= bypass_next_s;
      ir_r       <= ir_next_s;
      bist_sel_r <= bist_sel_next_s;
      tdo_en_r   <= (state_next_s == SH_IR) || (state_next_s == SH_DR);
      shift_dr_r <= (state_next_s == SH_DR) && bist_sel_next_s;
      tlr_r      <= (state_next_s == TLR);
      sh_en_r    <= ((state_next_s == CAP_DR) || (state_next_s == SH_DR)) && bist_sel_next_s;
      com_en_r   <= (state_next_s == UPD_DR) && bist_sel_next_s;
    end
  end

  // TDO source select; BIST_Shift_out is passed straight through because the
  // chain is clocked by the same edge, and pad-ring retiming follows.
  always_comb begin
    tdo_s = 1'b0;
    if (state_r == SH_IR) begin
      tdo_s = ir_sh_r[0];
    end else if (state_r == SH_DR) begin
      tdo_s = bist_sel_r ? BIST_Shift_out : bypass_r;
    end else begin
      tdo_s = 1'b0;
    end
  end

  assign TDO          = tdo_s;
  assign TDO_en       = tdo_en_r;
  assign Shift_DR     = shift_dr_r;
  assign Test_Log_Res = tlr_r;
  assign BIST_Sh_en   = sh_en_r;
  assign BIST_Com_en  = com_en_r;
  assign IR_out       = ir_r;

endmodule
